studio2_keypad: RTL and testbench

Keypad front end for the Studio II core. It converts PS/2 keyboard events into the state of the two 10-key hex keypads and latches the key-select value the CDP1802 writes with `OUT 2`. It drives the active-low EF3 and EF4 flags that the CPU polls. It sits between the PS/2 input and the `cdp1802` EF/IO ports, and replaces the ad-hoc keypad register in the top level.

---
 rtl/studio2_keypad.sv | 168 ++++++++++++++++
 tb/tb_studio2_keypad.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/studio2_keypad.sv
// studio2_keypad
// Keypad front end for the Studio II core. PS/2 make/break events are
// decoded into two 10-key hex keypads. Each key is held down for at least
// HOLD_CYCLES clocks after its make so short taps survive the CPU polling loop.
// The key-select nibble written by OUT 2 picks the key whose state is shown
// on the active-low EF3 (keypad 1) and EF4 (keypad 2) flags.
//
// Ports
//   clk       system clock (same as the CPU)
//   resetq    asynchronous active-low reset
//   ps2_key   [10] event toggle, [9] make, [8] extended, [7:0] scancode
//   io_n      CPU N lines
//   io_out    CPU output strobe, one cycle per OUT
//   io_dout   CPU output data
//   ef3_n     keypad 1 selected key down, active low (registered)
//   ef4_n     keypad 2 selected key down, active low (registered)
//   key_sel   latched key select
//   kp1_down  held state of keypad 1, bit k = key k
//   kp2_down  held state of keypad 2, bit k = key k
module studio2_keypad #(
    parameter int HOLD_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [10:0] ps2_key,
    input  logic [2:0]  io_n,
    input  logic        io_out,
    input  logic [7:0]  io_dout,
    output logic        ef3_n,
    output logic        ef4_n,
    output logic [3:0]  key_sel,
    output logic [9:0]  kp1_down,
    output logic [9:0]  kp2_down
);

    localparam int             CW        = 20;
    localparam int             NKEYS     = 20;
    localparam logic [CW-1:0]  HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

    logic             r_tog;
    logic             r_armed;
    logic [3:0]       r_key_sel;
    logic             r_ef3_n;
    logic             r_ef4_n;
    logic             w_event;
    logic [NKEYS-1:0] w_hit;
    logic [NKEYS-1:0] w_down;
    logic [15:0]      w_kp1_pad;
    logic [15:0]      w_kp2_pad;
    logic [3:0]       w_unused_dout;

    assign w_unused_dout = io_dout[7:4];

    // The first edge after reset only captures the toggle level, so whatever
    // toggle state the PS/2 side was left in cannot look like a new event.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_tog   <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_tog   <= ps2_key[10];
            r_armed <= 1'b1;
        end
    end

    assign w_event = r_armed & (ps2_key[10] != r_tog);

    // One-hot key decode: bits 0..9 keypad 1, bits 10..19 keypad 2.
    // Keypad 2 sits on the numpad, whose extended codes alias the cursor
    // cluster, so extended events are rejected there.
    always_comb begin
        w_hit = '0;
        case (ps2_key[7:0])
            8'h45: w_hit[0]  = 1'b1;
            8'h16: w_hit[1]  = 1'b1;
            8'h1E: w_hit[2]  = 1'b1;
            8'h26: w_hit[3]  = 1'b1;
            8'h25: w_hit[4]  = 1'b1;
            8'h2E: w_hit[5]  = 1'b1;
            8'h36: w_hit[6]  = 1'b1;
            8'h3D: w_hit[7]  = 1'b1;
            8'h3E: w_hit[8]  = 1'b1;
            8'h46: w_hit[9]  = 1'b1;
            8'h70: w_hit[10] = ~ps2_key[8];
            8'h69: w_hit[11] = ~ps2_key[8];
            8'h72: w_hit[12] = ~ps2_key[8];
            8'h7A: w_hit[13] = ~ps2_key[8];
            8'h6B: w_hit[14] = ~ps2_key[8];
            8'h73: w_hit[15] = ~ps2_key[8];
            8'h74: w_hit[16] = ~ps2_key[8];
            8'h6C: w_hit[17] = ~ps2_key[8];
            8'h75: w_hit[18] = ~ps2_key[8];
            8'h7D: w_hit[19] = ~ps2_key[8];
            default: w_hit = '0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_key
            logic [CW-1:0] r_cnt;
            logic          r_pend;
            logic          r_down;
            logic          w_make;
            logic          w_brk;
            logic          w_cnt_zero;

            assign w_make     = w_event & ps2_key[9] & w_hit[gi];
            assign w_brk      = w_event & ~ps2_key[9] & w_hit[gi];
            assign w_cnt_zero = (r_cnt == '0);

            // A release is only honoured once the hold counter has run out.
            // A break that arrives earlier is parked in r_pend and fires at
            // the first edge that sees the counter already at zero, which
            // gives a tap exactly HOLD_CYCLES cycles of visibility.
            always_ff @(posedge clk or negedge resetq) begin
                if (!resetq) begin
                    r_cnt  <= '0;
                    r_pend <= 1'b0;
                    r_down <= 1'b0;
                end else if (w_make) begin
                    r_down <= 1'b1;
                    r_pend <= 1'b0;
                    r_cnt  <= HOLD_LOAD;
                end else begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                    if (r_down && w_cnt_zero && (w_brk || r_pend)) begin
                        r_down <= 1'b0;
                        r_pend <= 1'b0;
                    end else if (r_down && w_brk) begin
                        r_pend <= 1'b1;
                    end
                end
            end

            assign w_down[gi] = r_down;
        end
    endgenerate

    // Padding to 16 bits lets the select nibble index directly; codes 10..15
    // land on the zero padding and read as "not down".
    assign w_kp1_pad = {6'b0, w_down[9:0]};
    assign w_kp2_pad = {6'b0, w_down[19:10]};

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_key_sel <= 4'd0;
            r_ef3_n   <= 1'b1;
            r_ef4_n   <= 1'b1;
        end else begin
            if (io_out && (io_n == 3'd2)) begin
                r_key_sel <= io_dout[3:0];
            end
            r_ef3_n <= ~((r_key_sel <= 4'd9) & w_kp1_pad[r_key_sel]);
            r_ef4_n <= ~((r_key_sel <= 4'd9) & w_kp2_pad[r_key_sel]);
        end
    end

    assign ef3_n    = r_ef3_n;
    assign ef4_n    = r_ef4_n;
    assign key_sel  = r_key_sel;
    assign kp1_down = w_down[9:0];
    assign kp2_down = w_down[19:10];

endmodule

// File: tb/tb_studio2_keypad.sv
module tb_studio2_keypad;

    localparam int H = 4;

    localparam logic [7:0] KP1_CODES [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                              8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    localparam logic [7:0] KP2_CODES [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                              8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic [10:0] ps2_key = 11'h400;
    logic [2:0]  io_n = 3'd0;
    logic        io_out = 1'b0;
    logic [7:0]  io_dout = 8'h00;
    logic        ef3_n;
    logic        ef4_n;
    logic [3:0]  key_sel;
    logic [9:0]  kp1_down;
    logic [9:0]  kp2_down;

    int checks = 0;
    int failures = 0;

    studio2_keypad #(.HOLD_CYCLES(H)) dut (
        .clk      (clk),
        .resetq   (resetq),
        .ps2_key  (ps2_key),
        .io_n     (io_n),
        .io_out   (io_out),
        .io_dout  (io_dout),
        .ef3_n    (ef3_n),
        .ef4_n    (ef4_n),
        .key_sel  (key_sel),
        .kp1_down (kp1_down),
        .kp2_down (kp2_down)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Keys are numbered 0..19 (keypad 2 at +10). A key's release is allowed
    // from edge (make edge + H) onwards; an earlier break is remembered.
    function automatic int map_key(input logic ext, input logic [7:0] code);
        for (int k = 0; k < 10; k++) begin
            if (code == KP1_CODES[k]) return k;
            if (!ext && code == KP2_CODES[k]) return 10 + k;
        end
        return -1;
    endfunction

    int       cyc = 0;
    bit       m_down [20];
    bit       m_req  [20];
    int       m_until[20];
    bit       m_tog, m_armed;
    bit [3:0] m_sel;
    bit       m_ef3 = 1'b1, m_ef4 = 1'b1;

    always @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int k = 0; k < 20; k++) begin
                m_down[k] = 0; m_req[k] = 0; m_until[k] = 0;
            end
            m_tog = 0; m_armed = 0; m_sel = 0; m_ef3 = 1; m_ef4 = 1;
        end else begin
            bit n3, n4;
            int key;
            cyc++;
            n3 = !(m_sel <= 9 && m_down[m_sel]);
            n4 = !(m_sel <= 9 && m_down[10 + m_sel]);
            key = -1;
            if (m_armed && ps2_key[10] != m_tog) key = map_key(ps2_key[8], ps2_key[7:0]);
            for (int k = 0; k < 20; k++) begin
                if (k == key && ps2_key[9]) begin
                    m_down[k] = 1; m_req[k] = 0; m_until[k] = cyc + H;
                end else begin
                    if (k == key && m_down[k]) m_req[k] = 1;
                    if (m_req[k] && cyc >= m_until[k]) begin
                        m_down[k] = 0; m_req[k] = 0;
                    end
                end
            end
            if (io_out && io_n == 3'd2) m_sel = io_dout[3:0];
            m_tog = ps2_key[10];
            m_armed = 1;
            m_ef3 = n3;
            m_ef4 = n4;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [9:0] e1, e2;
        for (int k = 0; k < 10; k++) begin
            e1[k] = m_down[k];
            e2[k] = m_down[10 + k];
        end
        check("model_kp1_down", 16'(kp1_down), 16'(e1));
        check("model_kp2_down", 16'(kp2_down), 16'(e2));
        check("model_key_sel", 16'(key_sel), 16'(m_sel));
        check("model_ef3_n", 16'(ef3_n), 16'(m_ef3));
        check("model_ef4_n", 16'(ef4_n), 16'(m_ef4));
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_key(input logic make, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], make, ext, code};
        $display("t=%0t ps2 %s ext=%0d code=%02h", $time, make ? "make " : "break", ext, code);
    endtask

    task automatic send_key(input logic make, input logic ext, input logic [7:0] code);
        @(negedge clk);
        set_key(make, ext, code);
    endtask

    task automatic out_cmd(input logic [2:0] n, input logic [7:0] d);
        @(negedge clk);
        io_n = n; io_dout = d; io_out = 1'b1;
        $display("t=%0t OUT %0d data=%02h", $time, n, d);
        @(negedge clk);
        io_out = 1'b0;
    endtask

    initial begin
        int hi, lo;

        // Reset with a stale toggle level of 1
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_kp1", 16'(kp1_down), 16'h0);
        check("reset_kp2", 16'(kp2_down), 16'h0);
        check("reset_ef3", 16'(ef3_n), 16'h1);
        check("reset_ef4", 16'(ef4_n), 16'h1);
        check("reset_sel", 16'(key_sel), 16'h0);

        // Keypad 1 make of key 5, select 5 then 6
        send_key(1'b1, 1'b0, 8'h2E);
        out_cmd(3'd2, 8'h05);
        check("kp1_make_vec", 16'(kp1_down), 16'h020);
        check("sel5_value", 16'(key_sel), 16'h5);
        check("ef3_lag", 16'(ef3_n), 16'h1);
        @(negedge clk);
        check("ef3_sel5", 16'(ef3_n), 16'h0);
        check("ef4_sel5", 16'(ef4_n), 16'h1);
        out_cmd(3'd2, 8'h06);
        @(negedge clk);
        check("ef3_sel6", 16'(ef3_n), 16'h1);
        send_key(1'b0, 1'b0, 8'h2E);
        @(negedge clk);
        check("kp1_break_late", 16'(kp1_down), 16'h0);

        // Tap stretch on keypad 2 key 0 with select 0
        out_cmd(3'd2, 8'h00);
        send_key(1'b1, 1'b0, 8'h70);
        hi = 0; lo = 0;
        @(negedge clk);
        hi += int'(kp2_down[0]); lo += int'(!ef4_n);
        set_key(1'b0, 1'b0, 8'h70);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            hi += int'(kp2_down[0]); lo += int'(!ef4_n);
        end
        check("tap_high_cycles", 16'(hi), 16'd4);
        check("tap_ef4_cycles", 16'(lo), 16'd4);
        check("tap_end_kp2", 16'(kp2_down), 16'h0);

        // Extended filter and an unmapped code
        send_key(1'b1, 1'b1, 8'h75);
        @(negedge clk);
        check("ext_ignored", 16'(kp2_down), 16'h0);
        send_key(1'b1, 1'b0, 8'h1C);
        @(negedge clk);
        check("unmapped_kp1", 16'(kp1_down), 16'h0);
        send_key(1'b1, 1'b0, 8'h75);
        @(negedge clk);
        check("numpad8", 16'(kp2_down), 16'h100);
        send_key(1'b0, 1'b0, 8'h75);

        // Re-make of key 3 on the cycle its pending release would fire
        out_cmd(3'd2, 8'h03);
        send_key(1'b1, 1'b0, 8'h26);      // edge E0
        send_key(1'b0, 1'b0, 8'h26);      // edge E1
        @(negedge clk);
        @(negedge clk);
        send_key(1'b1, 1'b0, 8'h26);      // edge E4, release would fire here
        @(negedge clk);
        check("remake_held", 16'(kp1_down[3]), 16'h1);
        send_key(1'b0, 1'b0, 8'h26);      // edge E6, hold runs to E8
        @(negedge clk);
        check("reload_e6", 16'(kp1_down[3]), 16'h1);
        @(negedge clk);
        check("reload_e7", 16'(kp1_down[3]), 16'h1);
        @(negedge clk);
        check("reload_e8", 16'(kp1_down[3]), 16'h0);

        // Select out of range and a non-2 OUT
        send_key(1'b1, 1'b0, 8'h45);
        out_cmd(3'd2, 8'h00);
        @(negedge clk);
        check("sel0_ef3", 16'(ef3_n), 16'h0);
        out_cmd(3'd2, 8'h0C);
        @(negedge clk);
        check("selC_ef3", 16'(ef3_n), 16'h1);
        check("selC_ef4", 16'(ef4_n), 16'h1);
        out_cmd(3'd4, 8'h01);
        check("out4_ignored", 16'(key_sel), 16'hC);

        // Reset mid-hold
        send_key(1'b1, 1'b0, 8'h16);
        out_cmd(3'd2, 8'h01);
        @(negedge clk);
        check("pre_reset_ef3", 16'(ef3_n), 16'h0);
        @(posedge clk);
        #2 resetq = 1'b0;
        $display("t=%0t reset asserted", $time);
        #1;
        check("async_kp1", 16'(kp1_down), 16'h0);
        check("async_kp2", 16'(kp2_down), 16'h0);
        check("async_ef3", 16'(ef3_n), 16'h1);
        check("async_sel", 16'(key_sel), 16'h0);
        @(negedge clk);
        ps2_key = {~ps2_key[10], ps2_key[9:0]};
        @(negedge clk);
        resetq = 1'b1;
        $display("t=%0t reset released", $time);
        repeat (2) @(negedge clk);
        check("rearm_no_phantom", 16'(kp1_down), 16'h0);
        send_key(1'b1, 1'b0, 8'h16);
        @(negedge clk);
        check("rearm_make", 16'(kp1_down), 16'h002);
        send_key(1'b0, 1'b0, 8'h16);
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
